pwm_duty_meter: RTL and testbench
=================================

# pwm_duty_meter

Receive-side companion to the board's PWM generator. The block samples a PWM waveform, such as the generator's `pwm` output looped back or an external source, and measures its high time and period in clock cycles. It converts each measurement to an integer duty percentage (0–100) and flags a stuck line. Results feed the 7-segment display path and the on-board self-check.

## Interface
Parameters:
- `CNT_W`, default 16: width of the high-time and period counters. The saturation/timeout value is 2^CNT_W−1.

Ports:
- `clk`, in, 1: system clock; all logic is on its rising edge.
- `rst`, in, 1: reset, synchronous and active-low.
- `pwm`, in, 1: asynchronous PWM input.
- `high_cnt`, out, CNT_W: high time of the last completed period, in cycles.
- `period_cnt`, out, CNT_W: length of the last completed period, rising edge to rising edge, in cycles.
- `duty`, out, 7: floor(high_cnt·100 / period_cnt), range 0..100.
- `valid`, out, 1: one-cycle pulse when `high_cnt`, `period_cnt`, `duty` and `stuck` update.
- `stuck`, out, 1: level; no rising edge seen for 2^CNT_W−1 cycles.
- `busy`, out, 1: divider running.

## Operation
- Input conditioning:
  - `pwm` passes through a 2-FF synchronizer, then an edge detector (1 register).
  - All counting uses the synchronized signal `pwm_s`.
- FSM states: WAIT_EDGE, HIGH, LOW, STUCK.
  - WAIT_EDGE (after reset): wait for the first rising edge. Go to HIGH and clear both counters. Produce no result.
  - HIGH: `hcnt` and `pcnt` increment each cycle. On a falling edge, go to LOW.
  - LOW: `pcnt` increments each cycle.
  - Period completion: a rising edge in LOW or HIGH completes a period. Capture `hcnt`/`pcnt`, request a divide, reload the counters for the new period, and stay in or return to HIGH.
  - Stuck detection: if `pcnt` reaches 2^CNT_W−1 in HIGH or LOW, go to STUCK.
- Entry to STUCK:
  - Set `stuck`=1 and `period_cnt`=all-ones.
  - If `pwm_s`=1: `high_cnt`=all-ones, `duty`=100. Otherwise `high_cnt`=0, `duty`=0.
  - Pulse `valid` once. No divide is performed.
- Exit from STUCK: a rising edge goes to HIGH. `stuck` clears on the next `valid`.
- Divide:
  - Dividend is `hcnt`·100, formed with shift-adds and CNT_W+7 bits wide. Divisor is `pcnt`.
  - Restoring shift-subtract, one quotient bit per cycle.
  - Quotient is truncated to 7 bits, which is safe because hcnt ≤ pcnt.
- Overrun: a period completing while `busy`=1 is dropped silently. Counters still restart, and `valid` is not pulsed for it.
- Simultaneous events: a rising edge in the same cycle that `pcnt` saturates takes priority, so the period completes normally with period = 2^CNT_W−1 and no STUCK.
- Reset mid-operation, from any state or from divide:
  - Next cycle: all outputs are 0 and the FSM is in WAIT_EDGE.
  - The divider aborts and the synchronizer clears to 0.
  - No `valid` pulse is produced.

## Timing
- Reset values: `high_cnt`=0, `period_cnt`=0, `duty`=0, `valid`=0, `stuck`=0, `busy`=0.
- Input latency: the `pwm` pin to edge detection takes 3 cycles. Measured counts are exact in cycles because the latency applies equally to both edges.
- Counter reload: the cycle the rising edge is detected counts as cycle 1 of the new period.
- Divider:
  - `busy` rises the cycle after period completion and stays high for exactly CNT_W+7 cycles.
  - On the cycle `busy` falls, `valid`=1 and all result outputs update together.
- Results hold until the next `valid`.
- Minimum reportable period: CNT_W+8 cycles. Shorter periods are decimated per the overrun rule.
- STUCK `valid` is issued the cycle after `pcnt` saturates.

## Structure
- Package `pwm_meter_pkg` holds:
  - the FSM state enum (WAIT_EDGE, HIGH, LOW, STUCK);
  - `DUTY_W`=7 and `PCT`=100;
  - the divider iteration-count function (CNT_W+7).
- Sub-module `seq_divider`:
  - parameterized dividend and divisor widths;
  - `start`/`busy`/`done` handshake plus `abort`, which is driven by reset;
  - quotient output.
- The top level holds the synchronizer, edge detector, FSM, counters and output registers.

## Test plan
All scenarios use CNT_W=16 and a 50 MHz clock.
- Reset: hold `rst`=0 for 5 cycles with `pwm` toggling → every output is 0. Release `rst` → no `valid` before the second rising edge.
- 25% duty, 25 cycles high / 75 low → `high_cnt`=25, `period_cnt`=100, `duty`=25. `valid` is one cycle wide and arrives 23 cycles after each rising edge is detected. Repeats every 100 cycles.
- Truncation, 10 high / 30 period → `duty`=33. 1 high / 200 period → `duty`=0. 199 high / 200 period → `duty`=99.
- Stuck high: hold `pwm`=1 for 70000 cycles → `stuck`=1, `duty`=100, `high_cnt`=`period_cnt`=16'hFFFF, a single `valid`. Resume 50/50 toggling at period 100 → next `valid` gives `stuck`=0, `duty`=50.
- Overrun: period 8 cycles, 4 high → `valid` only on periods whose divide finds `busy`=0. Every reported result is 4/8/50, and `busy` is never retriggered mid-divide.
- Reset mid-divide: assert `rst`=0 while `busy`=1 → next cycle `busy`=0, `valid`=0, all results 0, and the FSM is in WAIT_EDGE.

Source files
------------

// File: rtl/pwm_meter_pkg.sv
// Shared types and constants for the PWM duty meter.
package pwm_meter_pkg;

  typedef enum logic [1:0] {
    WAIT_EDGE,
    HIGH,
    LOW,
    STUCK
  } meter_state_e;

  localparam int unsigned DUTY_W = 7;
  localparam int unsigned PCT    = 100;

  // Dividend is hcnt*100, which needs DUTY_W extra bits; one quotient bit per cycle.
  function automatic int unsigned div_iters(input int unsigned cnt_w);
    return cnt_w + DUTY_W;
  endfunction

endpackage

// File: rtl/seq_divider.sv
// Restoring shift-subtract divider, one quotient bit per cycle, with synchronous abort.
module seq_divider #(
  parameter int unsigned DVD_W = 23,
  parameter int unsigned DVS_W = 16,
  parameter int unsigned QUO_W = 7
) (
  input  logic             clk,
  input  logic             abort,
  input  logic             start,
  input  logic [DVD_W-1:0] dividend,
  input  logic [DVS_W-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [QUO_W-1:0] quotient
);
  localparam int unsigned CW = $clog2(DVD_W);
  localparam logic [CW-1:0] LAST = CW'(DVD_W - 1);

  logic [DVD_W-1:0] dvd_q, dvd_nx;
  logic [DVS_W-1:0] dvs_q, rem_q, rem_nx;
  logic [DVS_W:0]   trial, diff;
  logic [CW-1:0]    cnt_q;
  logic             busy_q, fit;

  assign trial = {rem_q, dvd_q[DVD_W-1]};
  assign diff  = trial - {1'b0, dvs_q};
  // rem < divisor keeps trial < 2*divisor, so the borrow bit alone decides the fit.
  assign fit    = ~diff[DVS_W];
  assign rem_nx = fit ? diff[DVS_W-1:0] : trial[DVS_W-1:0];
  // Quotient bits shift into the low end as dividend bits leave the top.
  assign dvd_nx = {dvd_q[DVD_W-2:0], fit};

  assign busy     = busy_q;
  assign done     = busy_q && (cnt_q == LAST);
  assign quotient = dvd_nx[QUO_W-1:0];

  always_ff @(posedge clk) begin
    if (abort) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
      dvd_q  <= '0;
      dvs_q  <= '0;
      rem_q  <= '0;
    end else if (start && !busy_q) begin
      busy_q <= 1'b1;
      cnt_q  <= '0;
      dvd_q  <= dividend;
      dvs_q  <= divisor;
      rem_q  <= '0;
    end else if (busy_q) begin
      dvd_q <= dvd_nx;
      rem_q <= rem_nx;
      cnt_q <= cnt_q + CW'(1);
      if (done) busy_q <= 1'b0;
    end
  end

endmodule

// File: rtl/pwm_duty_meter.sv
// Measures high time, period and integer duty percentage of a sampled PWM input,
// flagging a line with no rising edge for a full counter span.
module pwm_duty_meter
  import pwm_meter_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pwm,
  output logic [CNT_W-1:0]  high_cnt,
  output logic [CNT_W-1:0]  period_cnt,
  output logic [DUTY_W-1:0] duty,
  output logic              valid,
  output logic              stuck,
  output logic              busy
);
  localparam int unsigned      DVD_W = div_iters(CNT_W);
  localparam logic [CNT_W-1:0] CMAX  = '1;
  localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

  logic              s1, pwm_s, pwm_d, rise, fall;
  meter_state_e      state_q, state_d;
  logic [CNT_W-1:0]  hcnt_q, hcnt_d, pcnt_q, pcnt_d, cap_h, cap_p;
  logic              complete, stuck_go, div_start, div_done, div_abort;
  logic [DVD_W-1:0]  hx, dividend;
  logic [DUTY_W-1:0] quo;

  always_ff @(posedge clk) begin
    if (!rst) begin
      s1    <= 1'b0;
      pwm_s <= 1'b0;
      pwm_d <= 1'b0;
    end else begin
      s1    <= pwm;
      pwm_s <= s1;
      pwm_d <= pwm_s;
    end
  end

  assign rise = pwm_s & ~pwm_d;
  assign fall = ~pwm_s & pwm_d;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= WAIT_EDGE;
      hcnt_q  <= '0;
      pcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      hcnt_q  <= hcnt_d;
      pcnt_q  <= pcnt_d;
    end
  end

  // Counters reload to 1: the edge-detect cycle is the first cycle of the new period.
  always_comb begin
    state_d  = state_q;
    hcnt_d   = hcnt_q;
    pcnt_d   = pcnt_q;
    complete = 1'b0;
    stuck_go = 1'b0;
    case (state_q)
      WAIT_EDGE, STUCK: begin
        if (rise) begin
          state_d = HIGH;
          hcnt_d  = ONE;
          pcnt_d  = ONE;
        end
      end
      HIGH, LOW: begin
        if (rise) begin
          complete = 1'b1;
          state_d  = HIGH;
          hcnt_d   = ONE;
          pcnt_d   = ONE;
        end else if (pcnt_q == CMAX) begin
          state_d  = STUCK;
          stuck_go = 1'b1;
        end else if (state_q == HIGH && fall) begin
          state_d = LOW;
          pcnt_d  = pcnt_q + ONE;
        end else begin
          pcnt_d = pcnt_q + ONE;
          if (state_q == HIGH) hcnt_d = hcnt_q + ONE;
        end
      end
      default: state_d = WAIT_EDGE;
    endcase
  end

  assign hx        = DVD_W'(hcnt_q);
  assign dividend  = (hx << 6) + (hx << 5) + (hx << 2);
  assign div_start = complete & ~busy;
  assign div_abort = ~rst;

  seq_divider #(
    .DVD_W(DVD_W),
    .DVS_W(CNT_W),
    .QUO_W(DUTY_W)
  ) u_div (
    .clk      (clk),
    .abort    (div_abort),
    .start    (div_start),
    .dividend (dividend),
    .divisor  (pcnt_q),
    .busy     (busy),
    .done     (div_done),
    .quotient (quo)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      high_cnt   <= '0;
      period_cnt <= '0;
      duty       <= '0;
      valid      <= 1'b0;
      stuck      <= 1'b0;
      cap_h      <= '0;
      cap_p      <= '0;
    end else begin
      valid <= 1'b0;
      if (stuck_go) begin
        stuck      <= 1'b1;
        period_cnt <= '1;
        high_cnt   <= pwm_s ? CMAX : '0;
        duty       <= pwm_s ? DUTY_W'(PCT) : '0;
        valid      <= 1'b1;
      end else if (div_done) begin
        stuck      <= 1'b0;
        high_cnt   <= cap_h;
        period_cnt <= cap_p;
        duty       <= quo;
        valid      <= 1'b1;
      end
      if (div_start) begin
        cap_h <= hcnt_q;
        cap_p <= pcnt_q;
      end
    end
  end

endmodule

// File: tb/tb_pwm_duty_meter.sv
// Directed bench for pwm_duty_meter with hand-computed expectations.
module tb_pwm_duty_meter;
  localparam int unsigned CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             pwm;
  logic [CNT_W-1:0] high_cnt, period_cnt;
  logic [6:0]       duty;
  logic             valid, stuck, busy;

  pwm_duty_meter #(.CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .pwm        (pwm),
    .high_cnt   (high_cnt),
    .period_cnt (period_cnt),
    .duty       (duty),
    .valid      (valid),
    .stuck      (stuck),
    .busy       (busy)
  );

  always #10 clk = ~clk;

  int   n_checks = 0, n_fail = 0;
  int   cyc = 0, nvalid = 0, nstuckv = 0, last_vcyc = 0, prev_vcyc = 0, rise_cyc = 0;
  int   width_err = 0, busy_err = 0, brun = 0, gap_err = 0, ovr_bad = 0, v0 = 0;
  logic valid_d = 1'b0;
  logic track_ovr = 1'b0;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (valid) begin
      nvalid++;
      prev_vcyc = last_vcyc;
      last_vcyc = cyc;
      if (stuck) nstuckv++;
      if (track_ovr) begin
        if (last_vcyc - prev_vcyc != 24) gap_err++;
        if (high_cnt != 16'd4 || period_cnt != 16'd8 || duty != 7'd50) ovr_bad++;
      end
    end
    if (valid && valid_d) width_err++;
    valid_d = valid;
    if (busy) brun++;
    else begin
      if (brun != 0 && brun != 23) busy_err++;
      brun = 0;
    end
  endtask

  task automatic drive(input logic lvl, input int n);
    if (lvl && !pwm) rise_cyc = cyc;
    pwm = lvl;
    repeat (n) step();
  endtask

  task automatic measure(input int h, input int p, input int expd);
    repeat (3) begin
      drive(1'b1, h);
      drive(1'b0, p - h);
    end
    check_eq("trunc_high_cnt", int'(high_cnt), h);
    check_eq("trunc_period_cnt", int'(period_cnt), p);
    check_eq("trunc_duty", int'(duty), expd);
  endtask

  initial begin
    rst = 1'b0;
    pwm = 1'b0;
    for (int i = 0; i < 5; i++) begin
      pwm = ~pwm;
      step();
    end
    check_eq("rst_high_cnt", int'(high_cnt), 0);
    check_eq("rst_period_cnt", int'(period_cnt), 0);
    check_eq("rst_duty", int'(duty), 0);
    check_eq("rst_valid", int'(valid), 0);
    check_eq("rst_stuck", int'(stuck), 0);
    check_eq("rst_busy", int'(busy), 0);

    rst = 1'b1;
    drive(1'b0, 10);
    for (int i = 0; i < 4; i++) begin
      if (i == 1) check_eq("no_valid_before_2nd_rise", nvalid, 0);
      drive(1'b1, 25);
      drive(1'b0, 75);
    end
    check_eq("d25_valid_count", nvalid, 3);
    check_eq("d25_high_cnt", int'(high_cnt), 25);
    check_eq("d25_period_cnt", int'(period_cnt), 100);
    check_eq("d25_duty", int'(duty), 25);
    check_eq("d25_pin_to_valid", last_vcyc - rise_cyc, 26);
    check_eq("d25_valid_spacing", last_vcyc - prev_vcyc, 100);
    check_eq("d25_stuck", int'(stuck), 0);

    measure(10, 30, 33);
    measure(1, 200, 0);
    measure(199, 200, 99);

    v0 = nvalid;
    drive(1'b1, 70000);
    check_eq("stuck_flag", int'(stuck), 1);
    check_eq("stuck_duty", int'(duty), 100);
    check_eq("stuck_high_cnt", int'(high_cnt), 65535);
    check_eq("stuck_period_cnt", int'(period_cnt), 65535);
    check_eq("stuck_valid_pulses", nstuckv, 1);
    check_eq("stuck_total_valids", nvalid - v0, 2);

    v0 = nvalid;
    drive(1'b0, 50);
    drive(1'b1, 50);
    drive(1'b0, 50);
    drive(1'b1, 50);
    drive(1'b0, 50);
    check_eq("resume_valids", nvalid - v0, 1);
    check_eq("resume_stuck", int'(stuck), 0);
    check_eq("resume_duty", int'(duty), 50);
    check_eq("resume_high_cnt", int'(high_cnt), 50);
    check_eq("resume_period_cnt", int'(period_cnt), 100);

    repeat (6) begin
      drive(1'b1, 4);
      drive(1'b0, 4);
    end
    v0 = nvalid;
    track_ovr = 1'b1;
    repeat (30) begin
      drive(1'b1, 4);
      drive(1'b0, 4);
    end
    track_ovr = 1'b0;
    check_eq("ovr_valid_count", nvalid - v0, 10);
    check_eq("ovr_gap_errors", gap_err, 0);
    check_eq("ovr_bad_results", ovr_bad, 0);
    check_eq("busy_run_errors", busy_err, 0);
    check_eq("valid_width_errors", width_err, 0);

    for (int i = 0; i < 64 && busy !== 1'b1; i++) begin
      pwm = ((i / 4) % 2) == 0;
      step();
    end
    check_eq("busy_before_rst", int'(busy), 1);
    rst = 1'b0;
    step();
    check_eq("midrst_busy", int'(busy), 0);
    check_eq("midrst_valid", int'(valid), 0);
    check_eq("midrst_high_cnt", int'(high_cnt), 0);
    check_eq("midrst_period_cnt", int'(period_cnt), 0);
    check_eq("midrst_duty", int'(duty), 0);
    check_eq("midrst_stuck", int'(stuck), 0);
    rst = 1'b1;
    step();
    step();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
